// File: rtl/c17_fault_sequencer.sv
// c17_fault_sequencer
// Stuck-at fault campaign controller for the c17 benchmark. It steps through
// every (site, stuck value) pair and sweeps all 32 input vectors against a
// golden and a fault-injected c17 copy. Each fault is dropped at its first
// detecting vector. The result of every fault and a running detection count
// are reported.
module c17_fault_sequencer #(
  parameter int NUM_SITES     = 11,
  parameter int SITE_W        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [4:0]        vec,
  output logic              fault_en,
  output logic [SITE_W-1:0] fault_site,
  output logic              fault_val,
  input  logic [1:0]        z_good,
  input  logic [1:0]        z_fault,
  output logic              busy,
  output logic              done,
  output logic              det_valid,
  output logic [SITE_W:0]   det_id,
  output logic              det_hit,
  output logic [4:0]        det_vec,
  output logic [SITE_W:0]   det_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_COMPARE, S_REPORT, S_DONE
  } state_t;

  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [SITE_W-1:0] LAST_SITE   = SITE_W'(NUM_SITES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic       last_vec;
  logic       last_fault;

  assign mismatch   = (z_good != z_fault);
  assign last_vec   = (vec == 5'd31);
  assign last_fault = (fault_site == LAST_SITE) && fault_val;

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so that every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Abort wins over everything outside IDLE.
  // NOTE: the next state defaults to the current state so that every path
  // assigns it, and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) begin
      if (start) state_nxt = S_APPLY;
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_APPLY:   state_nxt = S_SETTLE;
        S_SETTLE:  if (settle_cnt == 4'd0) state_nxt = S_COMPARE;
        S_COMPARE: state_nxt = (mismatch || last_vec) ? S_REPORT : S_APPLY;
        S_REPORT:  state_nxt = last_fault ? S_DONE : S_APPLY;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state.
  always_comb begin
    fault_en  = 1'b0;
    busy      = 1'b0;
    det_valid = 1'b0;
    unique case (state)
      S_APPLY, S_SETTLE, S_COMPARE: begin
        fault_en = 1'b1;
        busy     = 1'b1;
      end
      S_REPORT: begin
        fault_en  = 1'b1;
        busy      = 1'b1;
        det_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Campaign datapath. This covers the vector/fault stepping, the settle
  // counter, the latched detection result and the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec        <= '0;
      fault_site <= '0;
      fault_val  <= 1'b0;
      settle_cnt <= '0;
      done       <= 1'b0;
      det_id     <= '0;
      det_hit    <= 1'b0;
      det_vec    <= '0;
      det_cnt    <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        vec        <= '0;
        fault_site <= '0;
        fault_val  <= 1'b0;
        det_cnt    <= '0;
        done       <= 1'b0;
      end
    end else if (abort) begin
      done <= 1'b0;
    end else begin
      unique case (state)
        S_APPLY:  settle_cnt <= SETTLE_LOAD;
        S_SETTLE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        S_COMPARE: begin
          if (mismatch) begin
            det_id  <= {fault_site, fault_val};
            det_hit <= 1'b1;
            det_vec <= vec;
            det_cnt <= det_cnt + (SITE_W+1)'(1);
          end else if (last_vec) begin
            det_id  <= {fault_site, fault_val};
            det_hit <= 1'b0;
            det_vec <= '0;
          end else begin
            vec <= vec + 5'd1;
          end
        end
        S_REPORT: begin
          vec <= '0;
          if (last_fault) begin
            done <= 1'b1;
          end else if (!fault_val) begin
            fault_val <= 1'b1;
          end else begin
            fault_val  <= 1'b0;
            fault_site <= fault_site + SITE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_fault_sequencer.sv
// Bench for c17_fault_sequencer. It runs three sequencer instances (settle 2,
// 1 and 15). Each instance drives its own golden and injectable c17 models.
// The model stimulus is delayed by SETTLE_CYCLES-1 cycles. Expected per-fault
// reports are queued at start and checked as det_valid pulses arrive.
module tb_c17_fault_sequencer;

  localparam int NI = 3;

  typedef struct {
    logic [4:0] id;
    logic       hit;
    logic [4:0] v;
  } rep_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start      [NI];
  logic       abort      [NI];
  logic       fault_free [NI];
  logic [4:0] vec        [NI];
  logic       fault_en   [NI];
  logic [3:0] fault_site [NI];
  logic       fault_val  [NI];
  logic [1:0] z_good     [NI];
  logic [1:0] z_fault    [NI];
  logic       busy       [NI];
  logic       done       [NI];
  logic       det_valid  [NI];
  logic [4:0] det_id     [NI];
  logic       det_hit    [NI];
  logic [4:0] det_vec    [NI];
  logic [4:0] det_cnt    [NI];

  rep_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  // Reference c17 with an optional stuck-at at one of the 11 sites.
  function automatic logic [1:0] c17(input logic [4:0] v, input logic en,
                                     input logic [3:0] site, input logic sv);
    logic x1, x2, x3, x6, x7, g1, g2, g3, g4, z1, z2;
    x1 = v[4]; if (en && site == 4'd0) x1 = sv;
    x2 = v[3]; if (en && site == 4'd1) x2 = sv;
    x3 = v[2]; if (en && site == 4'd2) x3 = sv;
    x6 = v[1]; if (en && site == 4'd3) x6 = sv;
    x7 = v[0]; if (en && site == 4'd4) x7 = sv;
    g1 = ~(x1 & x3); if (en && site == 4'd5) g1 = sv;
    g2 = ~(x3 & x6); if (en && site == 4'd6) g2 = sv;
    g3 = ~(x2 & g2); if (en && site == 4'd7) g3 = sv;
    g4 = ~(g2 & x7); if (en && site == 4'd8) g4 = sv;
    z1 = ~(g1 & g3); if (en && site == 4'd9) z1 = sv;
    z2 = ~(g3 & g4); if (en && site == 4'd10) z2 = sv;
    return {z1, z2};
  endfunction

  function automatic logic [4:0] first_det(input int s, input logic sv, output logic hit);
    hit = 1'b0;
    for (int v = 0; v < 32; v++) begin
      if (c17(5'(v), 1'b0, 4'd0, 1'b0) != c17(5'(v), 1'b1, 4'(s), sv)) begin
        hit = 1'b1;
        return 5'(v);
      end
    end
    return 5'd0;
  endfunction

  function automatic logic [29:0] obs_of(input int i);
    return {vec[i], fault_en[i], fault_site[i], fault_val[i], busy[i], done[i],
            det_valid[i], det_id[i], det_hit[i], det_vec[i], det_cnt[i]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    logic [10:0] tup;
    logic [10:0] dtup;
    logic [10:0] sr [16];

    assign tup = {fault_en[g], fault_site[g], fault_val[g], vec[g]};

    always @(posedge clk) begin
      sr[0] <= tup;
      for (int k = 1; k < 16; k++) sr[k] <= sr[k-1];
    end

    if (S == 1) begin : g_nodly
      assign dtup = tup;
    end else begin : g_dly
      assign dtup = sr[S-2];
    end

    assign z_good[g]  = c17(dtup[4:0], 1'b0, 4'd0, 1'b0);
    assign z_fault[g] = fault_free[g] ? z_good[g]
                                      : c17(dtup[4:0], dtup[10], dtup[9:6], dtup[5]);

    c17_fault_sequencer #(
      .NUM_SITES    (11),
      .SITE_W       (4),
      .SETTLE_CYCLES(S)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .abort     (abort[g]),
      .vec       (vec[g]),
      .fault_en  (fault_en[g]),
      .fault_site(fault_site[g]),
      .fault_val (fault_val[g]),
      .z_good    (z_good[g]),
      .z_fault   (z_fault[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .det_valid (det_valid[g]),
      .det_id    (det_id[g]),
      .det_hit   (det_hit[g]),
      .det_vec   (det_vec[g]),
      .det_cnt   (det_cnt[g])
    );
  end

  // Start a campaign on instance i and score every report against the queue.
  task automatic run_campaign(input int i, input bit pulse, input bit chk_timing,
                              output logic [4:0] vec_id0, output int c1, output int c2);
    int         n;
    int         exp_hits;
    bit         fin;
    logic       hit;
    logic [4:0] v;
    rep_t       e;
    sb.delete();
    for (int s = 0; s < 11; s++) begin
      for (int b = 0; b < 2; b++) begin
        v = first_det(s, b[0], hit);
        if (fault_free[i]) begin hit = 1'b0; v = 5'd0; end
        e.id = 5'(s * 2 + b); e.hit = hit; e.v = v;
        sb.push_back(e);
      end
    end
    exp_hits = 0; fin = 0; c1 = -1; c2 = -1; vec_id0 = 5'h1f;
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0; n = 1;
    n_cmp++;
    if ({fault_site[i], fault_val[i], vec[i], fault_en[i], busy[i], done[i]} !== 13'b0000_0_00000_110) begin
      n_bad++;
      $display("FAIL start_state[%0d]: got %b expected 0000_0_00000_110", i,
               {fault_site[i], fault_val[i], vec[i], fault_en[i], busy[i], done[i]});
    end
    while (!fin && n < 15000) begin
      if (vec[i] == 5'd1 && c1 < 0) c1 = n;
      if (vec[i] == 5'd2 && c2 < 0) c2 = n;
      if (det_valid[i]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL extra_report[%0d]: got id %0d expected no report", i, det_id[i]);
        end else begin
          e = sb.pop_front();
          if (e.hit) exp_hits++;
          if ({det_id[i], det_hit[i], det_vec[i]} !== {e.id, e.hit, e.v}) begin
            n_bad++;
            $display("FAIL report[%0d]: got id %0d hit %b vec %0d expected id %0d hit %b vec %0d",
                     i, det_id[i], det_hit[i], det_vec[i], e.id, e.hit, e.v);
          end
          n_cmp++;
          if (det_cnt[i] !== 5'(exp_hits)) begin
            n_bad++;
            $display("FAIL det_cnt_run[%0d]: got %0d expected %0d", i, det_cnt[i], exp_hits);
          end
          if (e.id == 5'd0) vec_id0 = det_vec[i];
        end
      end
      if (done[i]) begin
        fin = 1;
        if (chk_timing) begin
          n_cmp++;
          if (n != 22 * (32 * (settle_of(i) + 2) + 1) + 1) begin
            n_bad++;
            $display("FAIL done_time[%0d]: got %0d expected %0d", i, n,
                     22 * (32 * (settle_of(i) + 2) + 1) + 1);
          end
        end
      end else begin
        start[i] = pulse && (n % 37 == 0);
        @(negedge clk); n++;
      end
    end
    start[i] = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL timeout[%0d]: got no done after %0d cycles expected done", i, n);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_reports[%0d]: got %0d left expected 0", i, sb.size());
    end
    n_cmp++;
    if (det_cnt[i] !== 5'(exp_hits)) begin
      n_bad++;
      $display("FAIL det_cnt_final[%0d]: got %0d expected %0d", i, det_cnt[i], exp_hits);
    end
    n_cmp++;
    if ({busy[i], fault_en[i]} !== 2'b00) begin
      n_bad++;
      $display("FAIL done_outputs[%0d]: got %b expected 00", i, {busy[i], fault_en[i]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; fault_free[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (obs_of(i) !== 30'd0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", i, obs_of(i));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    logic [4:0] v0;
    int         c1, c2;
    fault_free[0] = 1'b1;
    run_campaign(0, 1'b0, 1'b1, v0, c1, c2);
    fault_free[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_campaign();
    logic [4:0] v0;
    int         c1, c2;
    run_campaign(0, 1'b0, 1'b0, v0, c1, c2);
    n_cmp++;
    if (det_cnt[0] !== 5'd22) begin
      n_bad++;
      $display("FAIL full_det_cnt: got %0d expected 22", det_cnt[0]);
    end
    n_cmp++;
    if (v0 !== 5'd20) begin
      n_bad++;
      $display("FAIL x1_sa0_vec: got %0d expected 20", v0);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({done[0], busy[0], fault_en[0]} !== 3'b100) begin
      n_bad++;
      $display("FAIL done_sticky: got %b expected 100", {done[0], busy[0], fault_en[0]});
    end
  endtask

  task automatic test_start_while_busy();
    logic [4:0] v0;
    int         c1, c2;
    run_campaign(0, 1'b1, 1'b0, v0, c1, c2);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL done_hold_busy_run: got %b expected 1", done[0]);
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n_cmp++;
    if ({done[0], busy[0], det_cnt[0]} !== 7'b01_00000) begin
      n_bad++;
      $display("FAIL restart_clears: got %b expected 0100000", {done[0], busy[0], det_cnt[0]});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int   reps;
    int   hits04;
    int   extra;
    int   n;
    logic hit;
    logic [4:0] v;
    hits04 = 0;
    for (int f = 0; f < 5; f++) begin
      v = first_det(f / 2, f[0], hit);
      if (hit) hits04++;
    end
    reps = 0; n = 0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    while (reps < 5 && n < 5000) begin
      if (det_valid[0]) reps++;
      if (reps < 5) begin @(negedge clk); n++; end
    end
    n_cmp++;
    if (reps != 5) begin
      n_bad++;
      $display("FAIL abort_setup: got %0d reports expected 5", reps);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({fault_site[0], fault_val[0], fault_en[0]} !== 6'b0010_1_1) begin
      n_bad++;
      $display("FAIL abort_point: got %b expected 0010_1_1", {fault_site[0], fault_val[0], fault_en[0]});
    end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    n_cmp++;
    if ({busy[0], fault_en[0], done[0]} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_outputs: got %b expected 000", {busy[0], fault_en[0], done[0]});
    end
    n_cmp++;
    if (det_cnt[0] !== 5'(hits04)) begin
      n_bad++;
      $display("FAIL abort_det_cnt: got %0d expected %0d", det_cnt[0], hits04);
    end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (det_valid[0] || busy[0]) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] v0;
    int         c1, c2;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_run_busy: got %b expected 1", busy[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (obs_of(0) !== 30'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h expected 0", obs_of(0));
    end
    @(negedge clk);
    run_campaign(0, 1'b0, 1'b0, v0, c1, c2);
  endtask

  task automatic test_settle(input int i);
    logic [4:0] v0;
    int         c1, c2;
    int         p;
    p = settle_of(i) + 2;
    run_campaign(i, 1'b0, 1'b0, v0, c1, c2);
    n_cmp++;
    if (c1 != 1 + p) begin
      n_bad++;
      $display("FAIL vec1_cycle[%0d]: got %0d expected %0d", i, c1, 1 + p);
    end
    n_cmp++;
    if (c2 - c1 != p) begin
      n_bad++;
      $display("FAIL vec_period[%0d]: got %0d expected %0d", i, c2 - c1, p);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_full_campaign();
    test_start_while_busy();
    test_abort();
    test_reset_mid_run();
    test_settle(1);
    test_settle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
